wb2axi_master: RTL and testbench
================================

# wb2axi_master

Wishbone-classic-slave to AXI4 master bridge for single-beat accesses. It is the reverse of the peripheral-subsystem AXI-to-Wishbone path. It lets a Wishbone initiator, such as the test-IO port or a small DMA on the peripheral interconnect, reach AXI memory-mapped targets. Each Wishbone cycle becomes exactly one AXI transaction, and only one transaction is ever outstanding.

## Interface
Parameters:
- `WB_AD_WIDTH`, 32, Wishbone and AXI address width.
- `WB_DAT_WIDTH`, 32, data width; allowed values are 32 and 64.
- `AXI_ID_WIDTH`, 4, width of the AXI ID fields.
- `AXI_ID`, 0, constant ID driven on AW and AR.
- `TIMEOUT_CYCLES`, 255, response watchdog limit. Used only with `WB2AXI_TIMEOUT_EN`.

Ports (clock and reset first):
- `clk` in 1: the single clock.
- `rst` in 1: reset, synchronous and active-high.
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i` in 1 each: Wishbone cycle, strobe and write-enable.
- `wbs_addr_i` in `WB_AD_WIDTH`: byte address.
- `wbs_wdata_i` in `WB_DAT_WIDTH`: write data.
- `wbs_sel_i` in `WB_DAT_WIDTH/8`: byte selects.
- `wbs_rdata_o` out `WB_DAT_WIDTH`: registered read data.
- `wbs_ack_o`, `wbs_err_o` out 1 each: single-cycle completion pulses.
- `m_aw_valid` out 1, `m_aw_ready` in 1: write-address handshake.
- `m_aw_addr` out `WB_AD_WIDTH`: write address.
- `m_aw_id` out `AXI_ID_WIDTH`: write ID.
- `m_ar_*`: the same set as `m_aw_*`, for the read-address channel.
- `m_aw_len`/`m_ar_len` out 8 = 0; `m_*_size` out 3 = log2(`WB_DAT_WIDTH/8`); `m_*_burst` out 2 = INCR (2'b01). All constant.
- `m_w_valid` out 1, `m_w_ready` in 1: write-data handshake.
- `m_w_data` out `WB_DAT_WIDTH`: write data.
- `m_w_strb` out `WB_DAT_WIDTH/8`: write strobes.
- `m_w_last` out 1: constant 1.
- `m_b_valid` in 1, `m_b_ready` out 1, `m_b_resp` in 2, `m_b_id` in `AXI_ID_WIDTH`: write-response channel.
- `m_r_valid` in 1, `m_r_ready` out 1, `m_r_data` in `WB_DAT_WIDTH`, `m_r_resp` in 2, `m_r_last` in 1, `m_r_id` in `AXI_ID_WIDTH`: read-data channel.

## Operation
State machine states: IDLE, WR_REQ, WAIT_B, RD_REQ, WAIT_R, RESP.

- **IDLE, new request.** When `wbs_cyc_i & wbs_stb_i` is high, the bridge registers addr, wdata, sel and we.
  - Writes go to WR_REQ. Reads go to RD_REQ.
  - `m_aw_addr`/`m_ar_addr` carry the registered address unmodified.
- **WR_REQ.** `m_aw_valid` and `m_w_valid` rise together.
  - Each one drops in the cycle after its own handshake; an `aw_done`/`w_done` flag pair tracks them.
  - The state moves to WAIT_B once both have handshaken. The AW and W handshakes may occur in either order or in the same cycle.
- **WAIT_B.** `m_b_ready` = 1. On `m_b_valid`:
  - the bridge latches `err = m_b_resp[1]` (SLVERR or DECERR);
  - the state moves to RESP.
- **RD_REQ.** `m_ar_valid` = 1 until `m_ar_ready`, then the state moves to WAIT_R.
- **WAIT_R.** `m_r_ready` = 1. On `m_r_valid`:
  - `m_r_data` is latched into `wbs_rdata_o`;
  - `err = m_r_resp[1]` is latched;
  - the state moves to RESP.
  - `m_r_last` is ignored; a single beat is always expected.
- **RESP.** For one cycle, `wbs_ack_o = ~err` or `wbs_err_o = err`, gated by `wbs_cyc_i`. The state then returns to IDLE.
- **Master abort.** If `wbs_cyc_i` drops mid-transaction, the AXI transaction still runs to completion, because AXI transactions cannot be cancelled. In RESP the ack/err pulse is suppressed.
- **Write data.** Wishbone byte selects are passed unchanged to `m_w_strb`. A write with `sel` = 0 is still issued.
- **Response IDs.** `m_b_id` and `m_r_id` are not checked.

## Timing
- **Reset values.** Every valid, ready, ack and err output is 0, and `wbs_rdata_o` = 0. `rst` is system-wide, so the AXI targets are reset together with the bridge.
- **Minimum latency.** The request is sampled in cycle 0, `*_valid` is asserted in cycle 1, and the response is accepted in cycle 2 at the earliest. `wbs_ack_o` or `wbs_err_o` is asserted in cycle 3.
- **Valid stability.** A valid, once raised, is never lowered before its ready. Address, data and strobe are stable while valid is high.
- **Pulse width.** `wbs_ack_o` and `wbs_err_o` are exactly one cycle wide. They are never both high.
- **Back-to-back requests.** The next request is sampled no earlier than the cycle after RESP. This prevents a held `stb` from double-issuing.
- **Readies outside wait states.** `m_b_ready` and `m_r_ready` are 0 everywhere except WAIT_B and WAIT_R, apart from the timeout sink described under Configuration.

## Configuration
`WB2AXI_TIMEOUT_EN`:
- **When defined.**
  - An 8–16-bit counter, sized from `TIMEOUT_CYCLES`, clears on entry to WAIT_B or WAIT_R and increments every cycle spent there.
  - When it reaches `TIMEOUT_CYCLES`, the bridge goes to RESP with err = 1, so `wbs_err_o` pulses.
  - A `stale` flag is set. While `stale` is set, `m_b_ready`/`m_r_ready` stay high in IDLE, and the next late B or R beat is discarded and clears the flag.
  - New requests are not accepted while `stale` is set.
  - The address and data phases are never timed out, which keeps the bridge AXI-compliant.
- **When undefined.** The bridge waits in WAIT_B or WAIT_R indefinitely, and no counter or `stale` logic is built.

## Test plan
- **Write, immediate readies.** Write addr 0x1000, data 0xDEADBEEF, sel 0xF, with `aw_ready`, `w_ready` and `b_valid` (resp 0) all immediate. Required: AW and W handshake in cycle 1, `wbs_ack_o` in cycle 3, strb = 0xF.
- **Read with back-pressure.** Read addr 0x2004 with `ar_ready` delayed 4 cycles, then R with data 0x12345678, resp 0. Required: `ar_valid` held stable for 5 cycles, `wbs_rdata_o` = 0x12345678 with ack, single pulse.
- **Write handshake ordering.** Run three writes: `w_ready` 3 cycles before `aw_ready`, `aw_ready` before `w_ready`, and both in the same cycle. Required: each `*_valid` drops after its own handshake, and exactly one B is accepted per write.
- **Error response.** Return `b_resp` = 2'b11 on a write and `r_resp` = 2'b10 on a read. Required: `wbs_err_o` pulses and `wbs_ack_o` stays 0 in both cases.
- **Master abort and reset.** Drop `wbs_cyc_i` in WAIT_R, then deliver R. Required: no ack, and a return to IDLE. Separately, assert `rst` in WR_REQ. Required: all valids are 0 in the next cycle.
- **Timeout (`WB2AXI_TIMEOUT_EN`, `TIMEOUT_CYCLES` = 16).** Withhold B. Required: `wbs_err_o` pulses 16 cycles after entering WAIT_B. Then issue a new request and a late B. Required: the late B is sunk, and only then is the next AW issued.

Source files
------------

// File: rtl/wb2axi_master.sv
// wb2axi_master: Wishbone classic slave to AXI4 master bridge.
// Each Wishbone cycle becomes exactly one single-beat AXI transaction, with
// only one transaction outstanding at any time.
// Optional feature macro: WB2AXI_TIMEOUT_EN adds a response watchdog and a
// sink for late B/R beats that arrive after a timeout.
//
// Valid/ready rule on every AXI channel: a transfer happens on a rising edge
// where valid and ready are both high; the source keeps valid and its payload
// stable until that edge and drops valid in the following cycle.
module wb2axi_master #(
   parameter int WB_AD_WIDTH    = 32,
   parameter int WB_DAT_WIDTH   = 32,
   parameter int AXI_ID_WIDTH   = 4,
   parameter int AXI_ID         = 0,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                      clk,
   input  logic                      rst,
   // Wishbone classic slave
   input  logic                      wbs_cyc_i,
   input  logic                      wbs_stb_i,
   input  logic                      wbs_we_i,
   input  logic [WB_AD_WIDTH-1:0]    wbs_addr_i,
   input  logic [WB_DAT_WIDTH-1:0]   wbs_wdata_i,
   input  logic [WB_DAT_WIDTH/8-1:0] wbs_sel_i,
   output logic [WB_DAT_WIDTH-1:0]   wbs_rdata_o,
   output logic                      wbs_ack_o,
   output logic                      wbs_err_o,
   // AXI write address
   output logic                      m_aw_valid,
   input  logic                      m_aw_ready,
   output logic [WB_AD_WIDTH-1:0]    m_aw_addr,
   output logic [AXI_ID_WIDTH-1:0]   m_aw_id,
   output logic [7:0]                m_aw_len,
   output logic [2:0]                m_aw_size,
   output logic [1:0]                m_aw_burst,
   // AXI read address
   output logic                      m_ar_valid,
   input  logic                      m_ar_ready,
   output logic [WB_AD_WIDTH-1:0]    m_ar_addr,
   output logic [AXI_ID_WIDTH-1:0]   m_ar_id,
   output logic [7:0]                m_ar_len,
   output logic [2:0]                m_ar_size,
   output logic [1:0]                m_ar_burst,
   // AXI write data
   output logic                      m_w_valid,
   input  logic                      m_w_ready,
   output logic [WB_DAT_WIDTH-1:0]   m_w_data,
   output logic [WB_DAT_WIDTH/8-1:0] m_w_strb,
   output logic                      m_w_last,
   // AXI write response
   input  logic                      m_b_valid,
   output logic                      m_b_ready,
   input  logic [1:0]                m_b_resp,
   input  logic [AXI_ID_WIDTH-1:0]   m_b_id,
   // AXI read data
   input  logic                      m_r_valid,
   output logic                      m_r_ready,
   input  logic [WB_DAT_WIDTH-1:0]   m_r_data,
   input  logic [1:0]                m_r_resp,
   input  logic                      m_r_last,
   input  logic [AXI_ID_WIDTH-1:0]   m_r_id,
   // Current FSM state, for observation only
   output logic [2:0]                dbg_state_o
);

   localparam int SEL_W = WB_DAT_WIDTH / 8;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_WR_REQ = 3'd1;
   localparam logic [2:0] S_WAIT_B = 3'd2;
   localparam logic [2:0] S_RD_REQ = 3'd3;
   localparam logic [2:0] S_WAIT_R = 3'd4;
   localparam logic [2:0] S_RESP   = 3'd5;

   localparam logic [2:0] AXI_SIZE  = 3'($clog2(SEL_W));
   localparam logic [1:0] AXI_INCR  = 2'b01;

   logic [2:0]              state_q, state_d;
   logic                    aw_done_q, aw_done_d;
   logic                    w_done_q, w_done_d;
   logic [WB_AD_WIDTH-1:0]  addr_q, addr_d;
   logic [WB_DAT_WIDTH-1:0] wdata_q, wdata_d;
   logic [SEL_W-1:0]        sel_q, sel_d;
   logic                    err_q, err_d;
   logic [WB_DAT_WIDTH-1:0] rdata_q, rdata_d;

   logic aw_hs, w_hs, ar_hs;
   logic timeout_hit;   // watchdog expired this cycle while waiting for B/R
   logic stale;         // a timed-out response is still owed by the target

   // Channel outputs decoded from the registered state
   always_comb begin
      m_aw_valid = (state_q == S_WR_REQ) & ~aw_done_q;
      m_w_valid  = (state_q == S_WR_REQ) & ~w_done_q;
      m_ar_valid = (state_q == S_RD_REQ);
      m_b_ready  = (state_q == S_WAIT_B) | ((state_q == S_IDLE) & stale);
      m_r_ready  = (state_q == S_WAIT_R) | ((state_q == S_IDLE) & stale);
      wbs_ack_o  = (state_q == S_RESP) & wbs_cyc_i & ~err_q;
      wbs_err_o  = (state_q == S_RESP) & wbs_cyc_i & err_q;
   end

   assign aw_hs = m_aw_valid & m_aw_ready;
   assign w_hs  = m_w_valid & m_w_ready;
   assign ar_hs = m_ar_valid & m_ar_ready;

   assign m_aw_addr   = addr_q;
   assign m_ar_addr   = addr_q;
   assign m_aw_id     = AXI_ID_WIDTH'(AXI_ID);
   assign m_ar_id     = AXI_ID_WIDTH'(AXI_ID);
   assign m_aw_len    = 8'd0;
   assign m_ar_len    = 8'd0;
   assign m_aw_size   = AXI_SIZE;
   assign m_ar_size   = AXI_SIZE;
   assign m_aw_burst  = AXI_INCR;
   assign m_ar_burst  = AXI_INCR;
   assign m_w_data    = wdata_q;
   assign m_w_strb    = sel_q;
   assign m_w_last    = 1'b1;
   assign wbs_rdata_o = rdata_q;
   assign dbg_state_o = state_q;

   // Response IDs, RLAST and the low response bit carry no information here
   logic unused_sigs;
   assign unused_sigs = ^{m_b_id, m_r_id, m_r_last, m_b_resp[0], m_r_resp[0]};

   // Next-state and datapath capture for the bridge FSM
   always_comb begin
      state_d   = state_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      sel_d     = sel_q;
      err_d     = err_q;
      rdata_d   = rdata_q;
      case (state_q)
         S_IDLE: begin
            // Never start while a timed-out response is still to be sunk
            if (wbs_cyc_i & wbs_stb_i & ~stale) begin
               addr_d    = wbs_addr_i;
               wdata_d   = wbs_wdata_i;
               sel_d     = wbs_sel_i;
               err_d     = 1'b0;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = wbs_we_i ? S_WR_REQ : S_RD_REQ;
            end
         end
         S_WR_REQ: begin
            if (aw_hs) aw_done_d = 1'b1;
            if (w_hs)  w_done_d  = 1'b1;
            if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) state_d = S_WAIT_B;
         end
         S_WAIT_B: begin
            if (m_b_valid) begin
               err_d   = m_b_resp[1];
               state_d = S_RESP;
            end else if (timeout_hit) begin
               err_d   = 1'b1;
               state_d = S_RESP;
            end
         end
         S_RD_REQ: begin
            if (ar_hs) state_d = S_WAIT_R;
         end
         S_WAIT_R: begin
            if (m_r_valid) begin
               rdata_d = m_r_data;
               err_d   = m_r_resp[1];
               state_d = S_RESP;
            end else if (timeout_hit) begin
               err_d   = 1'b1;
               state_d = S_RESP;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Bridge state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         sel_q     <= '0;
         err_q     <= 1'b0;
         rdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         sel_q     <= sel_d;
         err_q     <= err_d;
         rdata_q   <= rdata_d;
      end
   end

`ifdef WB2AXI_TIMEOUT_EN
   localparam int TO_RAW_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam int TO_W     = (TO_RAW_W < 8) ? 8 : ((TO_RAW_W > 16) ? 16 : TO_RAW_W);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   logic [TO_W-1:0] cnt_q, cnt_d;
   logic            stale_q, stale_d;
   logic            waiting;
   logic            resp_in_wait;

   assign waiting      = (state_q == S_WAIT_B) | (state_q == S_WAIT_R);
   assign resp_in_wait = ((state_q == S_WAIT_B) & m_b_valid) |
                         ((state_q == S_WAIT_R) & m_r_valid);
   // The counter holds 0 outside the wait states, so it starts from 0 on entry
   // and fires on the TIMEOUT_CYCLES-th cycle spent waiting.
   assign timeout_hit  = waiting & (cnt_q == TO_LAST);
   assign stale        = stale_q;

   // Watchdog count and late-response bookkeeping
   always_comb begin
      cnt_d   = cnt_q;
      stale_d = stale_q;
      if (waiting) cnt_d = cnt_q + TO_W'(1);
      else         cnt_d = '0;
      if (timeout_hit & ~resp_in_wait) begin
         stale_d = 1'b1;
      end else if ((state_q == S_IDLE) & stale_q & (m_b_valid | m_r_valid)) begin
         // Only one transaction is ever owed, so the first beat is the late one
         stale_d = 1'b0;
      end
   end

   // Watchdog registers
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         stale_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         stale_q <= stale_d;
      end
   end
`else
   localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
   assign timeout_hit = 1'b0;
   assign stale       = 1'b0;
`endif

endmodule

// File: tb/tb_wb2axi_master.sv
// Testbench for wb2axi_master: table of single transactions against a
// configurable AXI target, plus hand-written multi-cycle sequences.
// Covers the WB2AXI_TIMEOUT_EN path when that macro is defined.
module tb_wb2axi_master;

   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int IDW = 4;
   localparam int TB_TIMEOUT = 16;
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_WAIT_R = 3'd4;

   logic            clk = 1'b0;
   logic            rst;
   logic            wbs_cyc_i, wbs_stb_i, wbs_we_i;
   logic [AW-1:0]   wbs_addr_i;
   logic [DW-1:0]   wbs_wdata_i;
   logic [DW/8-1:0] wbs_sel_i;
   logic [DW-1:0]   wbs_rdata_o;
   logic            wbs_ack_o, wbs_err_o;
   logic            m_aw_valid, m_aw_ready;
   logic [AW-1:0]   m_aw_addr;
   logic [IDW-1:0]  m_aw_id;
   logic [7:0]      m_aw_len;
   logic [2:0]      m_aw_size;
   logic [1:0]      m_aw_burst;
   logic            m_ar_valid, m_ar_ready;
   logic [AW-1:0]   m_ar_addr;
   logic [IDW-1:0]  m_ar_id;
   logic [7:0]      m_ar_len;
   logic [2:0]      m_ar_size;
   logic [1:0]      m_ar_burst;
   logic            m_w_valid, m_w_ready;
   logic [DW-1:0]   m_w_data;
   logic [DW/8-1:0] m_w_strb;
   logic            m_w_last;
   logic            m_b_valid, m_b_ready;
   logic [1:0]      m_b_resp;
   logic [IDW-1:0]  m_b_id;
   logic            m_r_valid, m_r_ready;
   logic [DW-1:0]   m_r_data;
   logic [1:0]      m_r_resp;
   logic            m_r_last;
   logic [IDW-1:0]  m_r_id;
   logic [2:0]      dbg_state_o;

   wb2axi_master #(
      .WB_AD_WIDTH(AW), .WB_DAT_WIDTH(DW), .AXI_ID_WIDTH(IDW),
      .AXI_ID(0), .TIMEOUT_CYCLES(TB_TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst),
      .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
      .wbs_addr_i(wbs_addr_i), .wbs_wdata_i(wbs_wdata_i), .wbs_sel_i(wbs_sel_i),
      .wbs_rdata_o(wbs_rdata_o), .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o),
      .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready), .m_aw_addr(m_aw_addr),
      .m_aw_id(m_aw_id), .m_aw_len(m_aw_len), .m_aw_size(m_aw_size),
      .m_aw_burst(m_aw_burst),
      .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_addr(m_ar_addr),
      .m_ar_id(m_ar_id), .m_ar_len(m_ar_len), .m_ar_size(m_ar_size),
      .m_ar_burst(m_ar_burst),
      .m_w_valid(m_w_valid), .m_w_ready(m_w_ready), .m_w_data(m_w_data),
      .m_w_strb(m_w_strb), .m_w_last(m_w_last),
      .m_b_valid(m_b_valid), .m_b_ready(m_b_ready), .m_b_resp(m_b_resp),
      .m_b_id(m_b_id),
      .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_data(m_r_data),
      .m_r_resp(m_r_resp), .m_r_last(m_r_last), .m_r_id(m_r_id),
      .dbg_state_o(dbg_state_o)
   );

   // ---------------- clock / reset / cycle index ----------------
   always #5 clk = ~clk;

   int tick = 0;
   always @(posedge clk) tick <= tick + 1;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1);
   end

   // ---------------- scoreboard counters ----------------
   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- AXI target model ----------------
   int          cfg_a_dly, cfg_w_dly, cfg_b_dly, cfg_r_dly;
   logic [1:0]  cfg_b_resp, cfg_r_resp;
   logic [31:0] cfg_r_data;
   logic        cfg_hold_b;
   logic [31:0] exp_addr, exp_wdata;
   logic [3:0]  exp_sel;

   int aw_wait, w_wait, ar_wait, b_wait, r_wait;
   int b_owed, r_owed;
   logic aw_got, w_got;
   int aw_vcyc, w_vcyc, ar_vcyc, b_hs, r_hs, payload_bad, aw_first;

   task automatic clear_stats();
      aw_vcyc = 0; w_vcyc = 0; ar_vcyc = 0; b_hs = 0; r_hs = 0;
      payload_bad = 0; aw_first = -1;
   endtask

   task automatic set_cfg(input int a, input int w, input int b, input int r,
                          input logic [1:0] bresp, input logic [1:0] rresp,
                          input logic [31:0] rdata);
      cfg_a_dly = a; cfg_w_dly = w; cfg_b_dly = b; cfg_r_dly = r;
      cfg_b_resp = bresp; cfg_r_resp = rresp; cfg_r_data = rdata; cfg_hold_b = 1'b0;
   endtask

   // Target decisions are made at the falling edge and sampled by the DUT at the rising edge
   always @(negedge clk) begin
      if (rst) begin
         m_aw_ready = 0; m_w_ready = 0; m_ar_ready = 0; m_b_valid = 0; m_r_valid = 0;
         aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
         b_owed = 0; r_owed = 0; aw_got = 0; w_got = 0;
      end else begin
         // B channel: serves responses already owed
         if (b_owed > 0 && !cfg_hold_b) begin
            if (b_wait >= cfg_b_dly) begin
               m_b_valid = 1; m_b_resp = cfg_b_resp;
               if (m_b_ready) begin b_hs++; b_owed--; b_wait = 0; end
            end else begin
               m_b_valid = 0; b_wait++;
            end
         end else m_b_valid = 0;
         // R channel
         if (r_owed > 0) begin
            if (r_wait >= cfg_r_dly) begin
               m_r_valid = 1; m_r_resp = cfg_r_resp; m_r_data = cfg_r_data;
               if (m_r_ready) begin r_hs++; r_owed--; r_wait = 0; end
            end else begin
               m_r_valid = 0; r_wait++;
            end
         end else m_r_valid = 0;
         // AW channel
         if (m_aw_valid) begin
            aw_vcyc++;
            if (aw_vcyc == 1) aw_first = tick;
            if (m_aw_addr !== exp_addr || m_aw_id !== 4'd0) payload_bad++;
            if (aw_wait >= cfg_a_dly) begin m_aw_ready = 1; aw_got = 1; aw_wait = 0; end
            else begin m_aw_ready = 0; aw_wait++; end
         end else m_aw_ready = 0;
         // W channel
         if (m_w_valid) begin
            w_vcyc++;
            if (m_w_data !== exp_wdata || m_w_strb !== exp_sel || m_w_last !== 1'b1) payload_bad++;
            if (w_wait >= cfg_w_dly) begin m_w_ready = 1; w_got = 1; w_wait = 0; end
            else begin m_w_ready = 0; w_wait++; end
         end else m_w_ready = 0;
         if (aw_got && w_got) begin b_owed++; aw_got = 0; w_got = 0; end
         // AR channel
         if (m_ar_valid) begin
            ar_vcyc++;
            if (m_ar_addr !== exp_addr || m_ar_id !== 4'd0) payload_bad++;
            if (ar_wait >= cfg_a_dly) begin m_ar_ready = 1; r_owed++; ar_wait = 0; end
            else begin m_ar_ready = 0; ar_wait++; end
         end else m_ar_ready = 0;
      end
   end

   // ---------------- Wishbone driver ----------------
   int t0;

   task automatic wb_xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] sel, output int done, output int n_ack,
                          output int n_err, output logic [31:0] rd);
      done = -1; n_ack = 0; n_err = 0; rd = '0;
      exp_addr = addr; exp_wdata = wdata; exp_sel = sel;
      clear_stats();
      @(negedge clk);
      wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = we;
      wbs_addr_i = addr; wbs_wdata_i = wdata; wbs_sel_i = sel;
      t0 = tick;
      while (tick - t0 < 40) begin
         @(negedge clk);
         if (wbs_ack_o) n_ack++;
         if (wbs_err_o) n_err++;
         if ((wbs_ack_o || wbs_err_o) && done < 0) begin
            done = tick - t0; rd = wbs_rdata_o;
            wbs_stb_i = 0;   // cyc stays up so a stretched pulse would still show
         end
         if (done >= 0 && tick - t0 >= done + 2) break;
      end
      wbs_cyc_i = 0; wbs_stb_i = 0;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  sel;
      int          a_dly, w_dly, b_dly, r_dly;
      logic [1:0]  resp;
      logic [31:0] rdata;
      int          exp_done;
      logic        exp_err;
      int          exp_a_cyc, exp_w_cyc;
   } vec_t;

   localparam int NV = 9;
   vec_t vecs[NV];

   function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] sel, input int a, input int w, input int b,
                               input int r, input logic [1:0] resp, input logic [31:0] rdata,
                               input int done, input logic err, input int acyc, input int wcyc);
      vec_t v;
      v.we = we; v.addr = addr; v.wdata = wdata; v.sel = sel;
      v.a_dly = a; v.w_dly = w; v.b_dly = b; v.r_dly = r; v.resp = resp; v.rdata = rdata;
      v.exp_done = done; v.exp_err = err; v.exp_a_cyc = acyc; v.exp_w_cyc = wcyc;
      return v;
   endfunction

   initial begin
      vec_t v;
      int done, na, ne, ack1, ack2, st10;
      logic [31:0] rd;

      //          we  addr         wdata        sel   a  w  b  r  resp   rdata         done err acyc wcyc
      vecs[0] = mk(1, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0, 2'b00, 32'h0,        3, 0, 1, 1);
      vecs[1] = mk(0, 32'h0000_2004, 32'h0,         4'hF, 4, 0, 0, 0, 2'b00, 32'h1234_5678, 7, 0, 5, 0);
      vecs[2] = mk(1, 32'h0000_1010, 32'hA5A5_A5A5, 4'hF, 3, 0, 0, 0, 2'b00, 32'h0,        6, 0, 4, 1);
      vecs[3] = mk(1, 32'h0000_1014, 32'h0102_0304, 4'h3, 0, 3, 1, 0, 2'b00, 32'h0,        7, 0, 1, 4);
      vecs[4] = mk(1, 32'h0000_1018, 32'hFFFF_0000, 4'hC, 2, 2, 0, 0, 2'b00, 32'h0,        5, 0, 3, 3);
      vecs[5] = mk(1, 32'h0000_1020, 32'h0BAD_F00D, 4'hF, 0, 0, 0, 0, 2'b11, 32'h0,        3, 1, 1, 1);
      vecs[6] = mk(0, 32'h0000_2010, 32'h0,         4'hF, 0, 0, 0, 0, 2'b10, 32'hCAFE_F00D, 3, 1, 1, 0);
      vecs[7] = mk(1, 32'h0000_1024, 32'h7777_7777, 4'h0, 1, 0, 0, 0, 2'b00, 32'h0,        4, 0, 2, 1);
      vecs[8] = mk(0, 32'h0000_2020, 32'h0,         4'hF, 0, 0, 0, 2, 2'b01, 32'h89AB_CDEF, 5, 0, 1, 0);

      rst = 1; wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
      wbs_addr_i = '0; wbs_wdata_i = '0; wbs_sel_i = '0;
      m_b_resp = 0; m_b_id = 0; m_r_data = 0; m_r_resp = 0; m_r_last = 1; m_r_id = 0;
      set_cfg(0, 0, 0, 0, 2'b00, 2'b00, 32'h0);
      exp_addr = 0; exp_wdata = 0; exp_sel = 0;
      clear_stats();

      // ---- reset values and constant fields ----
      repeat (3) @(negedge clk);
      check("rst_aw_valid", m_aw_valid, 0);
      check("rst_w_valid",  m_w_valid, 0);
      check("rst_ar_valid", m_ar_valid, 0);
      check("rst_b_ready",  m_b_ready, 0);
      check("rst_r_ready",  m_r_ready, 0);
      check("rst_ack_err",  {wbs_ack_o, wbs_err_o}, 0);
      check("rst_rdata",    wbs_rdata_o, 0);
      check("rst_state",    dbg_state_o, ST_IDLE);
      check("const_len",    {m_aw_len, m_ar_len}, 0);
      check("const_size",   {m_aw_size, m_ar_size}, {3'd2, 3'd2});
      check("const_burst",  {m_aw_burst, m_ar_burst}, 4'b0101);
      check("const_wlast",  m_w_last, 1);
      rst = 0;

      // ---- table-driven single transactions ----
      for (int i = 0; i < NV; i++) begin
         v = vecs[i];
         #1;
         set_cfg(v.a_dly, v.w_dly, v.b_dly, v.r_dly, v.resp, v.resp, v.rdata);
         wb_xfer(v.we, v.addr, v.wdata, v.sel, done, na, ne, rd);
         check($sformatf("v%0d_done_cycle", i), done, v.exp_done);
         check($sformatf("v%0d_ack_count", i), na, v.exp_err ? 0 : 1);
         check($sformatf("v%0d_err_count", i), ne, v.exp_err ? 1 : 0);
         check($sformatf("v%0d_payload", i), payload_bad, 0);
         if (v.we) begin
            check($sformatf("v%0d_aw_valid_cycles", i), aw_vcyc, v.exp_a_cyc);
            check($sformatf("v%0d_w_valid_cycles", i), w_vcyc, v.exp_w_cyc);
            check($sformatf("v%0d_b_accepted", i), b_hs, 1);
         end else begin
            check($sformatf("v%0d_ar_valid_cycles", i), ar_vcyc, v.exp_a_cyc);
            check($sformatf("v%0d_r_accepted", i), r_hs, 1);
            check($sformatf("v%0d_rdata", i), rd, v.rdata);
         end
      end

      // ---- held strobe: second request only after RESP ----
      #1;
      set_cfg(0, 0, 0, 0, 2'b00, 2'b00, 32'h0);
      exp_addr = 32'h0000_1100; exp_wdata = 32'h1357_9BDF; exp_sel = 4'hF;
      clear_stats();
      na = 0; ack1 = -1; ack2 = -1;
      @(negedge clk);
      wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 1;
      wbs_addr_i = exp_addr; wbs_wdata_i = exp_wdata; wbs_sel_i = exp_sel;
      t0 = tick;
      for (int c = 1; c <= 9; c++) begin
         @(negedge clk);
         if (wbs_ack_o) begin
            na++;
            if (ack1 < 0) ack1 = tick - t0; else if (ack2 < 0) ack2 = tick - t0;
         end
         if (c == 7) begin wbs_cyc_i = 0; wbs_stb_i = 0; end
      end
      check("b2b_ack_count", na, 2);
      check("b2b_first_ack", ack1, 3);
      check("b2b_second_ack", ack2, 7);
      check("b2b_aw_count", aw_vcyc, 2);
      check("b2b_b_count", b_hs, 2);

      // ---- master abort in WAIT_R ----
      #1;
      set_cfg(0, 0, 0, 5, 2'b00, 2'b00, 32'h5555_AAAA);
      exp_addr = 32'h0000_2040; exp_wdata = 0; exp_sel = 4'hF;
      clear_stats();
      na = 0; ne = 0; st10 = -1;
      @(negedge clk);
      wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0;
      wbs_addr_i = exp_addr; wbs_sel_i = exp_sel;
      t0 = tick;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (wbs_ack_o) na++;
         if (wbs_err_o) ne++;
         if (c == 3) begin
            check("abort_in_wait_r", dbg_state_o, ST_WAIT_R);
            wbs_cyc_i = 0; wbs_stb_i = 0;
         end
         if (c == 10) st10 = dbg_state_o;
      end
      check("abort_no_ack", na, 0);
      check("abort_no_err", ne, 0);
      check("abort_r_accepted", r_hs, 1);
      check("abort_back_idle", st10, ST_IDLE);
      check("abort_rdata", wbs_rdata_o, 32'h5555_AAAA);

      // ---- reset while in WR_REQ ----
      #1;
      set_cfg(5, 5, 0, 0, 2'b00, 2'b00, 32'h0);
      exp_addr = 32'h0000_1200; exp_wdata = 32'h2468_ACE0; exp_sel = 4'hF;
      clear_stats();
      @(negedge clk);
      wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 1;
      wbs_addr_i = exp_addr; wbs_wdata_i = exp_wdata; wbs_sel_i = exp_sel;
      repeat (2) @(negedge clk);
      check("rstwr_aw_valid_before", {m_aw_valid, m_w_valid}, 2'b11);
      rst = 1; wbs_cyc_i = 0; wbs_stb_i = 0;
      @(negedge clk);
      check("rstwr_valids_after", {m_aw_valid, m_w_valid, m_ar_valid}, 3'b000);
      check("rstwr_state", dbg_state_o, ST_IDLE);
      @(negedge clk);
      rst = 0;

      // ---- sanity transaction after reset ----
      #1;
      set_cfg(0, 0, 0, 0, 2'b00, 2'b00, 32'h0F0F_0F0F);
      wb_xfer(0, 32'h0000_2100, 32'h0, 4'hF, done, na, ne, rd);
      check("post_rst_done", done, 3);
      check("post_rst_rdata", rd, 32'h0F0F_0F0F);

`ifdef WB2AXI_TIMEOUT_EN
      // ---- watchdog on withheld B, then sink of the late B ----
      #1;
      set_cfg(0, 0, 0, 0, 2'b00, 2'b00, 32'h0);
      cfg_hold_b = 1;
      wb_xfer(1, 32'h0000_3000, 32'h1111_2222, 4'hF, done, na, ne, rd);
      check("to_err_cycle", done, 18);
      check("to_err_count", ne, 1);
      check("to_ack_count", na, 0);
      #1;
      cfg_b_dly = 5; cfg_hold_b = 0;
      wb_xfer(1, 32'h0000_3004, 32'h3333_4444, 4'hF, done, na, ne, rd);
      check("to_next_aw_cycle", aw_first - t0, 7);
      check("to_b_count", b_hs, 2);
      check("to_next_done", done, 14);
      check("to_next_ack", na, 1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
